// File: rtl/dmem_line_ctrl.sv
// Line-granular backing data memory with fixed access latency (IDLE/BUSY/ACK FSM).
// Optional read/write completion counters when DMEM_STATS_EN is defined.
module dmem_line_ctrl #(
    parameter int LINES   = 512,
    parameter int LATENCY = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    input  logic         enable_i,
    input  logic         write_i,
`ifdef DMEM_STATS_EN
    output logic [31:0]  rd_cnt_o,
    output logic [31:0]  wr_cnt_o,
`endif
    output logic         ack_o,
    output logic [255:0] data_o
);
    localparam int IW = $clog2(LINES);
    localparam int CW = $clog2(LATENCY);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            wr_q, wr_d;
    logic [255:0]    wdata_q, wdata_d;
    logic [255:0]    rdata_q, rdata_d;
    logic            ack_q, ack_d;
    logic [255:0]    mem_q [LINES];
    logic            commit;

    // Offset bits and bits above the index field are don't-care (address wraps).
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:5+IW], addr_i[4:0]};

    assign commit = (state_q == BUSY) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    idx_d   = addr_i[5 +: IW];
                    wr_d    = write_i;
                    if (write_i) wdata_d = data_i;
                    cnt_d   = CW'(LATENCY - 2);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (commit) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                    if (!wr_q) rdata_d = mem_q[idx_q];
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
        end
    end

    // Storage is never reset; reset forces IDLE so a pending write cannot commit.
    always_ff @(posedge clk_i) begin
        if (commit && wr_q) mem_q[idx_q] <= wdata_q;
    end

    assign ack_o  = ack_q;
    assign data_o = rdata_q;

`ifdef DMEM_STATS_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (commit) begin
            if (wr_q) wr_cnt_q <= wr_cnt_q + 32'd1;
            else      rd_cnt_q <= rd_cnt_q + 32'd1;
        end
    end

    assign rd_cnt_o = rd_cnt_q;
    assign wr_cnt_o = wr_cnt_q;
`endif
endmodule

// File: tb/tb_dmem_line_ctrl.sv
// Scoreboard bench for dmem_line_ctrl: stimulus pushes expected ack cycle/data,
// a negedge monitor pops and compares on every ack pulse.
module tb_dmem_line_ctrl;
    localparam int LINES   = 512;
    localparam int LATENCY = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic         enable;
    logic         write;
    logic         ack;
    logic [255:0] rdata;
`ifdef DMEM_STATS_EN
    logic [31:0]  rd_cnt, wr_cnt;
`endif

    dmem_line_ctrl #(.LINES(LINES), .LATENCY(LATENCY)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .addr_i   (addr),
        .data_i   (wdata),
        .enable_i (enable),
        .write_i  (write),
`ifdef DMEM_STATS_EN
        .rd_cnt_o (rd_cnt),
        .wr_cnt_o (wr_cnt),
`endif
        .ack_o    (ack),
        .data_o   (rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic [255:0] data;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           total = 0;
    int           bad = 0;
    logic [255:0] last_rd;

    localparam logic [255:0] P0  = {8{32'h0000_0A0A}};
    localparam logic [255:0] P1  = {8{32'h1111_2222}};
    localparam logic [255:0] A5  = {32{8'hA5}};
    localparam logic [255:0] P4  = {8{32'h4444_4444}};
    localparam logic [255:0] JNK = {8{32'hDEAD_BEEF}};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && ack) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got ack at cycle %0d want none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_cycle", 256'(cyc), 256'(e.cyc));
                check("ack_data", rdata, e.data);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic w, input logic [255:0] d,
                         input logic [255:0] exp_d);
        exp_t e;
        @(negedge clk);
        addr = a; write = w; wdata = d; enable = 1'b1;
        @(posedge clk);
        #1;
        e.cyc = cyc + LATENCY - 1;
        e.data = exp_d;
        sb.push_back(e);
        enable = 1'b0; write = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; write = 1'b0; addr = '0; wdata = '0;
        dut.mem_q[0] = P0;
        dut.mem_q[1] = P1;
        dut.mem_q[3] = A5;
        dut.mem_q[4] = P4;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 256'(ack), 256'(0));
        check("rst_data", rdata, '0);
        rst = 1'b0;

        // read line 3, then confirm data_o holds
        issue(32'h60, 1'b0, '0, A5);
        last_rd = A5;
        wait_idle();
        repeat (4) @(negedge clk);
        check("hold_data", rdata, A5);

        // write then read-after-write; write ack must leave data_o alone
        issue(32'h40, 1'b1, 256'h1234, last_rd);
        wait_idle();
        issue(32'h40, 1'b0, '0, 256'h1234);
        last_rd = 256'h1234;
        wait_idle();

        // inputs wiggle during BUSY, including a would-be write
        issue(32'h20, 1'b0, '0, P1);
        last_rd = P1;
        @(negedge clk);
        addr = 32'h80; write = 1'b1; wdata = JNK; enable = 1'b1;
        repeat (3) @(negedge clk);
        enable = 1'b0; write = 1'b0;
        wait_idle();
        check("busy_no_write", dut.mem_q[4], P4);

        // enable held high across ACK: two requests, acks 11 cycles apart
        @(negedge clk);
        addr = 32'h60; write = 1'b0; enable = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{cyc + LATENCY - 1, A5});
        sb.push_back('{cyc + 2 * LATENCY, A5});
        repeat (21) @(posedge clk);
        #1;
        enable = 1'b0;
        last_rd = A5;
        wait_idle();
        repeat (15) @(posedge clk);

        // reset in the middle of a write
        @(negedge clk);
        addr = 32'h00; write = 1'b1; wdata = JNK; enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0; write = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ack", 256'(ack), 256'(0));
        check("midrst_data", rdata, '0);
        check("midrst_mem", dut.mem_q[0], P0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("midrst_mem_late", dut.mem_q[0], P0);
        last_rd = '0;

        // address wrap, then stats tally of 2 reads + 1 write
        issue(32'h4000, 1'b0, '0, P0);
        wait_idle();
        issue(32'h60, 1'b0, '0, A5);
        last_rd = A5;
        wait_idle();
        issue(32'hA0, 1'b1, 256'h5555, last_rd);
        wait_idle();
        @(negedge clk);
        check("wr_commit", dut.mem_q[5], 256'h5555);
        check("final_data", rdata, A5);
`ifdef DMEM_STATS_EN
        check("rd_cnt", 256'(rd_cnt), 256'(2));
        check("wr_cnt", 256'(wr_cnt), 256'(1));
`endif
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_line_ctrl.md
Name: dmem_line_ctrl

Overview:
- Line-granular backing data memory behind the data cache.
- Serves the cache's miss-fill and write-back traffic over the 256-bit enable/write/ack memory interface.
- Models fixed off-chip access latency with a small FSM and cycle counter, so cache stall behaviour is exercised with realistic timing.
- Sits directly downstream of the cache: its ports connect one-to-one to the cache's mem_* ports.

Parameters:
- LINES, 512, number of 256-bit lines in the storage array (power of two, ≥ 2).
- LATENCY, 10, cycles from request acceptance to ack (≥ 2).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- addr_i  input  32  byte address of the request; line index = addr_i[5+log2(LINES)-1:5].
- data_i  input  256  write line data.
- enable_i  input  1  request valid.
- write_i  input  1  1 = write line, 0 = read line; sampled with enable_i.
- ack_o  output  1  one-cycle completion pulse.
- data_o  output  256  read line data.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE, counter = 0, ack_o = 0, data_o = 0, latched address/data/write cleared.
  - Storage array is NOT cleared; it is initialised only by testbench $readmemb or direct hierarchical writes.
- FSM states: IDLE, BUSY, ACK.
- IDLE:
  - Rising edge with enable_i = 1 accepts the request.
  - Latches line index, write_i and data_i (data_i latched only when write_i = 1).
  - Loads counter = LATENCY-2 and moves to BUSY.
  - enable_i = 0: stays in IDLE.
- BUSY:
  - Counter decrements each edge.
  - On the edge where counter = 0, moves to ACK.
  - For a read, the same edge loads data_o from array[index].
  - For a write, the same edge writes the latched data into array[index]; data_o is unchanged.
  - addr_i, data_i, write_i and enable_i are ignored while BUSY (request is fully latched).
- ACK:
  - ack_o = 1 for exactly this cycle; next edge moves to IDLE.
  - enable_i high during ACK is NOT a new request.
- Latency: request accepted at edge T → ack_o high in the cycle following edge T+LATENCY-1. That is LATENCY cycles after acceptance, counting the ACK cycle.
- Back-to-back requests: earliest next acceptance is at the edge ending the cycle after ACK (one IDLE cycle minimum between requests).
- Output hold:
  - data_o holds the last read line until the next read completes; writes never modify data_o.
  - ack_o is registered, never combinational from inputs.
- Address handling:
  - addr_i[4:0] ignored (line aligned).
  - Bits above the index field ignored, so addresses wrap modulo LINES*32 bytes.
- Read-after-write to the same line returns the newly written data (write commits before the read request can be accepted).
- Reset mid-operation (BUSY or ACK):
  - Aborts immediately; no ack pulse is produced.
  - A write whose commit edge has not occurred is dropped; the array line keeps its old value.
- write_i = 1 with enable_i = 0 has no effect.

Optional Feature:
- Macro: DMEM_STATS_EN.
- Defined:
  - Adds outputs rd_cnt_o [31:0] and wr_cnt_o [31:0].
  - Each increments on the ACK cycle of a completed read or write respectively; counters wrap at 2^32.
  - Reset clears both to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset then read: preload array[3] = 256'hA5…A5; enable_i = 1, write_i = 0, addr_i = 32'h60 accepted at edge 0 → ack_o high only in cycle 10 (LATENCY = 10), data_o = A5…A5 from cycle 10 and held afterwards.
- Write then read: write addr 32'h40, data 256'h1234 → ack after 10 cycles; read addr 32'h40 one cycle after ack → data_o = 256'h1234, data_o unchanged during the write.
- Input change while BUSY: accept read of addr 32'h20, then drive addr_i = 32'h80, write_i = 1 during BUSY → returns array[1], array[4] unmodified, single ack.
- enable_i held high through ACK: exactly one ack per request, next request accepted after the IDLE cycle, second ack 11 cycles after the first.
- Reset mid-write: accept write at addr 32'h00, assert rst_i at cycle 5 → ack_o = 0, data_o = 0, array[0] retains preloaded value.
- Wrap and stats: with DMEM_STATS_EN, read addr 32'h4000 (LINES = 512) → returns array[0]; after 2 reads + 1 write, rd_cnt_o = 2, wr_cnt_o = 1.
